// File: rtl/vote_session_ctrl.sv
// Four-voter ballot session sequencer: opens a voting window, latches one ballot per voter,
// tallies a majority verdict and holds it on the display for a fixed time.
module vote_session_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int HOLD_CYCLES    = 500,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] yes,
  input  logic [3:0] no,
  output logic [3:0] voted,
  output logic       busy,
  output logic       done,
  output logic [3:1] O
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VOTING = 2'd1,
    S_TALLY  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_timer_next;
  logic [3:0]       r_ballot;
  logic [3:0]       w_ballot_next;
  logic [3:0]       r_voted;
  logic [3:0]       w_voted_next;
  logic [3:1]       r_o;
  logic [3:1]       w_o_next;
  logic             r_done;
  logic             w_done_next;
  logic             r_busy;
  logic             w_busy_next;

  logic [3:0]       w_accept;
  logic [2:0]       w_yes_cnt;
  logic [3:1]       w_verdict;
  logic             w_timer_zero;
  logic [CNT_W-1:0] w_timer_dec;

  // A press counts only for an unlocked voter pressing exactly one of the two buttons.
  assign w_accept     = ~r_voted & (yes ^ no);
  assign w_yes_cnt    = {2'b00, r_ballot[0]} + {2'b00, r_ballot[1]}
                      + {2'b00, r_ballot[2]} + {2'b00, r_ballot[3]};
  assign w_timer_zero = (r_timer == '0);
  assign w_timer_dec  = w_timer_zero ? '0 : r_timer - 1'b1;

  always_comb begin
    if (w_yes_cnt < 3'd2) begin
      w_verdict = 3'b100;
    end else if (w_yes_cnt == 3'd2) begin
      w_verdict = 3'b010;
    end else begin
      w_verdict = 3'b001;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_ballot <= '0;
      r_voted  <= '0;
      r_o      <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_timer  <= w_timer_next;
      r_ballot <= w_ballot_next;
      r_voted  <= w_voted_next;
      r_o      <= w_o_next;
      r_done   <= w_done_next;
      r_busy   <= w_busy_next;
    end
  end

  // Abort outranks a full electorate, which outranks the timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_VOTING;
        end
      end
      S_VOTING: begin
        if (abort) begin
          w_state_next = S_IDLE;
        end else if ((r_voted == 4'hF) || w_timer_zero) begin
          w_state_next = S_TALLY;
        end
      end
      S_TALLY: begin
        w_state_next = S_RESULT;
      end
      S_RESULT: begin
        if (start) begin
          w_state_next = S_VOTING;
        end else if (w_timer_zero) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_timer_next  = r_timer;
    w_ballot_next = r_ballot;
    w_voted_next  = r_voted;
    w_o_next      = r_o;
    w_done_next   = 1'b0;
    w_busy_next   = (w_state_next == S_VOTING) || (w_state_next == S_TALLY);
    case (r_state)
      S_IDLE: begin
        w_o_next     = '0;
        w_voted_next = '0;
        if (start) begin
          w_ballot_next = '0;
          w_timer_next  = TMO_LOAD;
        end
      end
      S_VOTING: begin
        if (abort) begin
          w_ballot_next = '0;
          w_voted_next  = '0;
          w_timer_next  = '0;
        end else begin
          // Ballots still land on the timeout edge itself.
          w_ballot_next = r_ballot | (w_accept & yes);
          w_voted_next  = r_voted | w_accept;
          w_timer_next  = w_timer_dec;
        end
      end
      S_TALLY: begin
        w_o_next     = w_verdict;
        w_done_next  = 1'b1;
        w_timer_next = HOLD_LOAD;
      end
      S_RESULT: begin
        if (start) begin
          w_o_next      = '0;
          w_ballot_next = '0;
          w_voted_next  = '0;
          w_timer_next  = TMO_LOAD;
        end else if (w_timer_zero) begin
          w_o_next     = '0;
          w_voted_next = '0;
        end else begin
          w_timer_next = w_timer_dec;
        end
      end
      default: begin
        w_o_next      = '0;
        w_voted_next  = '0;
        w_ballot_next = '0;
      end
    endcase
  end

  assign voted = r_voted;
  assign busy  = r_busy;
  assign done  = r_done;
  assign O     = r_o;

endmodule

// File: doc/vote_session_ctrl.md
Name: vote_session_ctrl

Overview:
Sequences one four-voter ballot session around the majority-vote decision.
- Opens a voting window on start.
- Latches one yes/no ballot per voter and locks it.
- Closes the window when all four have voted or a timeout expires.
- Tallies, holds the 3-bit verdict for a fixed display time, then returns to idle.

Sits between the front-panel voter buttons/debouncers and the result LEDs.

Parameters:
TIMEOUT_CYCLES, 1000, maximum VOTING duration in clock cycles (>=2)
HOLD_CYCLES, 500, RESULT display duration in clock cycles (>=1)
CNT_W, 16, timer width; must hold max(TIMEOUT_CYCLES, HOLD_CYCLES)-1

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  synchronous, active-low reset
start  in  1  open a session (level sampled each edge)
abort  in  1  cancel an open session, no verdict
yes  in  4  yes[i]=1: voter i presses YES
no  in  4  no[i]=1: voter i presses NO
voted  out  4  voted[i]=1: voter i's ballot is locked
busy  out  1  1 in VOTING or TALLY
done  out  1  one-cycle pulse when verdict becomes valid
O  out  3 [3:1]  verdict: 3'b100 fail (<2 yes), 3'b010 tie (2 yes), 3'b001 pass (>=3 yes); 3'b000 = no verdict

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, timer=0, ballots=0, voted=0, O=3'b000, busy=0, done=0. Reset mid-session discards all ballots; no done pulse.
- FSM states: IDLE, VOTING, TALLY, RESULT. All outputs are registered.
- IDLE: O=000, voted=0. If start=1, next state is VOTING, ballots/voted are cleared, and timer loads TIMEOUT_CYCLES-1.
- VOTING:
  - busy=1; timer decrements each cycle.
  - For each i with voted[i]=0:
    - yes[i]=1, no[i]=0: record yes, set voted[i].
    - no[i]=1, yes[i]=0: record no, set voted[i].
    - Both or neither: ignore.
  - Locked voters ignore all further presses.
  - Exit priority:
    - abort=1 -> IDLE (ballots cleared, no done).
    - Else registered voted==4'b1111 -> TALLY.
    - Else timer==0 -> TALLY.
  - A ballot presented at the edge that leaves VOTING on timeout is still recorded.
  - start is ignored in VOTING.
  - Missing voters count as no.
  - VOTING lasts at most TIMEOUT_CYCLES cycles.
- TALLY:
  - One cycle; busy=1.
  - yes_cnt = popcount of the yes ballots, 3 bits, range 0..4.
  - Verdict: 0/1 -> 100, 2 -> 010, 3/4 -> 001.
  - At the exit edge: O loads the verdict, done=1 for the following cycle, timer loads HOLD_CYCLES-1, next state RESULT.
  - abort is ignored in TALLY.
- RESULT:
  - busy=0; O and voted hold; timer decrements.
  - timer==0 -> IDLE; O and voted clear at that edge.
  - start=1 in RESULT -> VOTING directly: O cleared, ballots cleared, timer reloaded. start takes priority over the hold expiring.
  - abort is ignored in RESULT.
- Latency: the edge capturing the last ballot is k. TALLY is entered at edge k+1. O is valid and done=1 after edge k+2.
- done never asserts for two consecutive cycles and never after abort or reset.
- O is always one-hot or 000.

Test Plan:
1. TIMEOUT_CYCLES=20, HOLD_CYCLES=8. start pulse, then yes=4'b0111 for one cycle and no[3]=1 next cycle. Required: voted=1111; O=001 and done pulse 2 edges after voter 3 locks; O held 8 cycles then 000; busy low in RESULT.
2. start; yes=0011 only; no further input. Required: TALLY after exactly 20 VOTING cycles; O=010; voted=0011.
3. start; voter0 yes, then voter0 no, then voter0 yes+no simultaneously, plus voter1 yes+no. Required: voted=0001, voter1 unlocked; on timeout O=100 (1 yes).
4. start; yes=1111 all in one cycle. Required: O=001 after 2 edges. Then start asserted on RESULT cycle 3: O=000, busy=1, voted=0000 the next cycle, new session timed from 20.
5. start; two yes ballots; abort=1. Required: IDLE next cycle, O=000, voted=0000, no done. Repeat with rst_n=0 mid-VOTING: same result, and the next start opens a clean session.
6. Timeout-edge race: ballot yes[2] presented on the final VOTING cycle (timer==0). Required: ballot counted in the tally; O reflects it.
